seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller for the icoboard seven-segment display. Holds one 5-bit code per digit, drives one digit at a time with hex-decoded segments, and inserts blanking between digits to suppress ghosting. Host-side writes go to shadow registers and reach the display only at a frame boundary after an explicit commit, so a multi-digit update never tears.

## Interface
- DIGITS, 4: number of multiplexed digits, 1..8.
- TICKS_PER_DIGIT, 1000: clk cycles each digit is driven (SHOW), ≥1.
- BLANK_TICKS, 16: clk cycles with all anodes off after each digit (BLANK), ≥0; 0 removes BLANK.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the shadow register.
- wr_addr  in  3  digit index. Writes with wr_addr ≥ DIGITS are ignored.
- wr_data  in  6  bit5 = dp, bit4 = blank, bits3:0 = hex value.
- commit  in  1  one-cycle request to transfer shadow→active at the next frame boundary.
- an  out  DIGITS  one-hot digit enable, active-high.
- seg  out  7  segments, bit0 = a … bit6 = g, active-high.
- dp  out  1  decimal point, active-high.
- pending  out  1  commit accepted, transfer not yet done.
- frame_done  out  1  one-cycle pulse: first output cycle of a new frame.

## Operation
- Reset:
  - an, seg, dp, pending and frame_done all 0.
  - Shadow and active registers all 6'h10 (blank, dp off).
  - FSM in SHOW, digit 0, counter 0.
- FSM states are SHOW and BLANK.
- SHOW:
  - Lasts TICKS_PER_DIGIT cycles.
  - Then goes to BLANK, or, if BLANK_TICKS = 0, to SHOW of the next digit.
- BLANK:
  - Lasts BLANK_TICKS cycles.
  - Then goes to SHOW of digit+1, wrapping DIGITS-1 → 0.
- Frame period is DIGITS×(TICKS_PER_DIGIT+BLANK_TICKS) cycles.
- Frame boundary is the last cycle of digit DIGITS-1: its last BLANK cycle, or its last SHOW cycle if BLANK_TICKS = 0.
- Decode in SHOW, for the current digit d:
  - an = 1<<d.
  - dp = active[d][5].
  - seg = 0 if active[d][4], otherwise hex decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Decode in BLANK: an = 0, seg = 0, dp = 0.
- Writes: wr_en updates shadow[wr_addr] at the clock edge. Writes never touch active registers directly.
- Commit:
  - commit sets pending on the next edge.
  - At the frame-boundary edge with pending = 1: active ← shadow (all digits), pending ← 0.
  - A commit asserted in the boundary cycle itself is not honoured at that boundary. It sets pending and transfers at the following boundary.
  - Commit while pending = 1 has no additional effect.
- Write and commit in the same cycle: the write is part of the committed data.
- Write in the boundary cycle while pending: it lands in shadow only. The transfer uses the pre-write shadow; the new value needs a new commit.
- rst mid-frame: everything returns to reset values on that edge, and any pending transfer is discarded.

## Timing
- All outputs are registered. an/seg/dp reflect the FSM state with 1 cycle latency.
- After rst falls (first edge with rst = 0 captures SHOW digit 0), an = 0001 is visible on the following cycle.
- frame_done is high for exactly the one cycle in which an first shows digit 0 of a frame, excluding the first frame after reset.
- Active data committed at a boundary edge is visible on digit 0 in that same frame_done cycle.
- Counter width is clog2(max(TICKS_PER_DIGIT, BLANK_TICKS)+1). Digit counter wraps modulo DIGITS; no other wrap.

## Test plan
All scenarios use DIGITS=4, TICKS_PER_DIGIT=4, BLANK_TICKS=1 (frame = 20 cycles).

1. Reset release with no writes:
   - an sequence per frame: 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000.
   - seg = 0 throughout; frame_done pulses every 20 cycles, starting at cycle 21.
2. Write 0x1,0x2,0x3,0xF to digits 0–3, then commit mid-frame:
   - pending = 1 until the boundary; no display change before it.
   - Next frame shows seg 06, 5B, 4F, 71, with frame_done and pending = 0 in that cycle.
3. Commit asserted exactly in the boundary cycle:
   - The display is unchanged for one more frame.
   - Transfer happens at the following boundary.
4. Same-cycle wr_en (digit 2, data 6'h28) and commit:
   - Digit 2 shows seg 7F with dp = 1 after the boundary.
   - wr_addr = 5 writes are ignored.
5. Blank bit: write 6'h18 to digit 1 and commit → digit 1 slot has an = 0010, seg = 0.
6. rst asserted mid-SHOW of digit 2 with pending = 1:
   - Next cycle: an = 0, pending = 0, active all blank.
   - Scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - host write port and display outputs of the segment scan controller
interface seg_scan_if #(
   parameter int DIGITS = 4
);
   logic              wr_en;
   logic [2:0]        wr_addr;
   logic [5:0]        wr_data;
   logic              commit;
   logic [DIGITS-1:0] an;
   logic [6:0]        seg;
   logic              dp;
   logic              pending;
   logic              frame_done;

   modport master (
      output wr_en, wr_addr, wr_data, commit,
      input  an, seg, dp, pending, frame_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, commit,
      output an, seg, dp, pending, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan with blanking and frame-synchronous commit
module seg_scan_ctrl #(
   parameter int DIGITS          = 4,
   parameter int TICKS_PER_DIGIT = 1000,
   parameter int BLANK_TICKS     = 16
) (
   input  logic      clk,
   input  logic      rst,
   seg_scan_if.slave bus
);
   localparam int MAXT = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
   localparam int CW   = $clog2(MAXT + 1);
   localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

   typedef enum logic {S_SHOW, S_BLANK} state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     digit_q, digit_d, digit_next;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [5:0]        shadow_q [DIGITS];
   logic [5:0]        active_q [DIGITS];
   logic              pending_q;
   logic              bnd_q;
   logic              boundary;
   logic [5:0]        cur;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              frame_done_q;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign digit_next = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;

   // The frame ends on the last cycle spent on the final digit, blank phase included when present
   assign boundary = (digit_q == DIGIT_LAST) &&
                     ((BLANK_TICKS == 0) ? (state_q == S_SHOW  && cnt_q == SHOW_LAST)
                                         : (state_q == S_BLANK && cnt_q == BLANK_LAST));

   // Scan sequencer: SHOW each digit, optionally followed by a BLANK gap
   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
         S_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d = '0;
               if (BLANK_TICKS == 0) begin
                  digit_d = digit_next;
               end else begin
                  state_d = S_BLANK;
               end
            end
         end
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d   = '0;
               state_d = S_SHOW;
               digit_d = digit_next;
            end
         end
         default: begin
            state_d = S_SHOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Segment/anode decode of the current scan position, registered one cycle later
   always_comb begin
      an_d  = '0;
      seg_d = '0;
      dp_d  = 1'b0;
      cur   = active_q[digit_q];
      if (state_q == S_SHOW) begin
         an_d[digit_q] = 1'b1;
         dp_d          = cur[5];
         seg_d         = cur[4] ? 7'h00 : hex7(cur[3:0]);
      end
   end

   // Scan state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_SHOW;
         digit_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         digit_q <= digit_d;
         cnt_q   <= cnt_d;
      end
   end

   // Shadow writes, commit bookkeeping, frame-boundary transfer and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            shadow_q[i] <= 6'h10;
            active_q[i] <= 6'h10;
         end
         pending_q    <= 1'b0;
         bnd_q        <= 1'b0;
         an_q         <= '0;
         seg_q        <= '0;
         dp_q         <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         if (bus.wr_en && (32'(bus.wr_addr) < DIGITS)) begin
            shadow_q[bus.wr_addr[DW-1:0]] <= bus.wr_data;
         end
         // The transfer samples the shadow as it stood before this edge's write
         if (boundary && pending_q) begin
            active_q  <= shadow_q;
            pending_q <= 1'b0;
         end else if (bus.commit) begin
            pending_q <= 1'b1;
         end
         bnd_q        <= boundary;
         frame_done_q <= bnd_q;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.pending    = pending_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for the seven-segment scan controller
module tb_seg_scan_ctrl;
   localparam int DIGITS = 4;
   localparam int TPD    = 4;
   localparam int BT     = 1;

   typedef struct packed {
      int          tag;
      logic [27:0] segs;
      logic [3:0]  dp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   frames_seen = 0;
   exp_t sb [$];

   always #5 clk = ~clk;

   seg_scan_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_ctrl #(
      .DIGITS(DIGITS),
      .TICKS_PER_DIGIT(TPD),
      .BLANK_TICKS(BT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fd();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!bus.frame_done && n < 40);
      check("fd_wait", bus.frame_done, 1);
   endtask

   task automatic wr(input logic [2:0] a, input logic [5:0] d, input logic cm);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.commit  = cm;
      tick();
      bus.wr_en   = 1'b0;
      bus.commit  = 1'b0;
   endtask

   task automatic cmt();
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
   endtask

   task automatic push(input int tag, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] d);
      exp_t e;
      e.tag  = tag;
      e.segs = {s3, s2, s1, s0};
      e.dp   = d;
      sb.push_back(e);
   endtask

   task automatic release_check();
      int   n;
      logic segnz;
      rst = 1'b0;
      tick();
      check("an_after_release", bus.an, 4'b0001);
      check("seg_after_release", bus.seg, 0);
      n     = 1;
      segnz = 1'b0;
      while (!bus.frame_done && n < 60) begin
         tick();
         n++;
         if (bus.seg != 7'h00) segnz = 1'b1;
      end
      check("fd_first_cycle", n, 21);
      check("seg_blank_first_frame", segnz, 0);
   endtask

   // Monitor: follows every frame after a frame_done pulse and settles it against the scoreboard
   logic [6:0] sc [4];
   logic [3:0] dc;
   initial begin
      int   pos;
      bit   tracking;
      int   digit;
      int   slot;
      exp_t e;
      tracking = 1'b0;
      pos      = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            tracking = 1'b0;
         end else begin
            if (bus.frame_done) begin
               if (tracking) check("fd_period", pos, 19);
               tracking = 1'b1;
               pos      = 0;
               frames_seen++;
            end else if (tracking) begin
               pos++;
               if (pos > 19) begin
                  check("fd_missing", bus.frame_done, 1);
                  tracking = 1'b0;
               end
            end
            if (tracking) begin
               digit = pos / 5;
               slot  = pos % 5;
               check("an_scan", bus.an, (slot < 4) ? (32'd1 << digit) : 32'd0);
               if (slot == 0) begin
                  sc[digit] = bus.seg;
                  dc[digit] = bus.dp;
               end else if (slot < 4) begin
                  check("seg_steady", bus.seg, sc[digit]);
                  check("dp_steady", bus.dp, dc[digit]);
               end else begin
                  check("seg_gap", bus.seg, 0);
                  check("dp_gap", bus.dp, 0);
               end
               if (pos == 19) begin
                  while (sb.size() > 0 && sb[0].tag < frames_seen) begin
                     check("sb_stale", sb[0].tag, frames_seen);
                     void'(sb.pop_front());
                  end
                  if (sb.size() > 0 && sb[0].tag == frames_seen) begin
                     e = sb.pop_front();
                     for (int d = 0; d < 4; d++) begin
                        check("frame_seg", sc[d], e.segs[7*d +: 7]);
                     end
                     check("frame_dp", dc, e.dp);
                  end
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_addr = 3'd0;
      bus.wr_data = 6'd0;
      bus.commit  = 1'b0;
      rst         = 1'b1;
      repeat (3) tick();
      check("rst_an", bus.an, 0);
      check("rst_seg", bus.seg, 0);
      check("rst_dp", bus.dp, 0);
      check("rst_pending", bus.pending, 0);
      check("rst_fd", bus.frame_done, 0);

      release_check();
      push(frames_seen + 1, 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);

      // Write 1,2,3,F then commit mid-frame
      wr(3'd0, 6'h01, 1'b0);
      wr(3'd1, 6'h02, 1'b0);
      wr(3'd2, 6'h03, 1'b0);
      wr(3'd3, 6'h0F, 1'b0);
      cmt();
      check("pending_set", bus.pending, 1);
      repeat (13) tick();
      check("pending_hold", bus.pending, 1);
      wait_fd();
      check("pending_clear", bus.pending, 0);
      push(frames_seen + 1, 7'h06, 7'h5B, 7'h4F, 7'h71, 4'b0000);

      // Commit in the boundary cycle is deferred one frame
      wr(3'd0, 6'h0A, 1'b0);
      repeat (17) tick();
      cmt();
      check("pending_boundary_commit", bus.pending, 1);
      wait_fd();
      check("pending_deferred", bus.pending, 1);
      push(frames_seen + 1, 7'h06, 7'h5B, 7'h4F, 7'h71, 4'b0000);
      wait_fd();
      check("pending_done_deferred", bus.pending, 0);
      push(frames_seen + 1, 7'h77, 7'h5B, 7'h4F, 7'h71, 4'b0000);

      // Same-cycle write+commit, and an out-of-range address
      wr(3'd2, 6'h28, 1'b1);
      check("pending_wr_commit", bus.pending, 1);
      wr(3'd5, 6'h00, 1'b0);
      wait_fd();
      push(frames_seen + 1, 7'h77, 7'h5B, 7'h7F, 7'h71, 4'b0100);

      // Blank bit on digit 1
      wr(3'd1, 6'h18, 1'b1);
      wait_fd();
      push(frames_seen + 1, 7'h77, 7'h00, 7'h7F, 7'h71, 4'b0100);
      wait_fd();

      // Reset during digit 2 with a commit pending
      wr(3'd3, 6'h05, 1'b1);
      check("pending_before_rst", bus.pending, 1);
      repeat (10) tick();
      check("an_before_rst", bus.an, 4'b0100);
      rst = 1'b1;
      tick();
      check("midrst_an", bus.an, 0);
      check("midrst_seg", bus.seg, 0);
      check("midrst_pending", bus.pending, 0);
      check("midrst_fd", bus.frame_done, 0);
      tick();
      release_check();
      push(frames_seen + 1, 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);
      wait_fd();
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
